mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the multicycle core (requester 0) and a camera/frame DMA engine (requester 1).
- Sits between the core/DMA and the Memory instance inside the top level.
- One memory transaction per cycle. Bounded DMA bursts prevent core starvation.
- Read data is registered and returned one cycle after grant.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the core/DMA unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_DMA_BURST = 1'b1;

    localparam logic [0:0] REQ_CORE = 1'b0;
    localparam logic [0:0] REQ_DMA  = 1'b1;

    localparam int MAX_BURST_DEFAULT = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between the core (req 0) and a frame DMA (req 1),
// with bounded DMA bursts and registered read return.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_last,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    logic [0:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [0:0]        rr_last_q, rr_last_d;
    logic              c_gnt_d, d_gnt_d;
    logic              c_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0] c_rdata_q, d_rdata_q;

    always_comb begin
        c_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (c_req && (!d_req || rr_last_q == REQ_DMA)) begin
                    c_gnt_d   = 1'b1;
                    rr_last_d = REQ_CORE;
                end else if (d_req) begin
                    d_gnt_d   = 1'b1;
                    rr_last_d = REQ_DMA;
                    if (!d_last) begin
                        state_d = ST_DMA_BURST;
                        cnt_d   = 8'd1;
                    end
                end
            end
            default: begin
                if (!d_req) begin
                    c_gnt_d = c_req;
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (c_req && cnt_q >= BURST_LIM) begin
                    // Forced handover: a pending d_last stays with the DMA.
                    c_gnt_d = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    d_gnt_d = 1'b1;
                    cnt_d   = sat_inc8(cnt_q);
                    if (d_last) begin
                        state_d   = ST_IDLE;
                        cnt_d     = 8'd0;
                        rr_last_d = REQ_DMA;
                    end
                end
            end
        endcase
    end

    assign c_gnt     = c_gnt_d;
    assign d_gnt     = d_gnt_d;
    assign mem_addr  = d_gnt_d ? d_addr  : c_addr;
    assign mem_wdata = d_gnt_d ? d_wdata : c_wdata;
    assign mem_we    = (c_gnt_d & c_we) | (d_gnt_d & d_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            rr_last_q  <= REQ_DMA;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_last_q  <= rr_last_d;
            c_rvalid_q <= c_gnt_d & ~c_we;
            d_rvalid_q <= d_gnt_d & ~d_we;
            if (c_gnt_d && !c_we) c_rdata_q <= mem_rdata;
            if (d_gnt_d && !d_we) d_rdata_q <= mem_rdata;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word-addressed memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_last, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_last(d_last), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    // Memory contents are preloaded whenever reset is high.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_last = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        cyc();
        cyc();
        reset = 0;
        #1;
        chk("rst_c_gnt", 32'(c_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        // Core read of 0x10
        c_req = 1; c_addr = 32'h10;
        #1;
        chk("rd_c_gnt", 32'(c_gnt), 32'd1);
        chk("rd_d_gnt", 32'(d_gnt), 32'd0);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        cyc();
        idle_inputs();
        #1;
        chk("rd_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);

        // Idle mux shows core values with no write
        c_addr = 32'h44; c_wdata = 32'h1234; d_addr = 32'h88;
        #1;
        chk("idle_mem_addr", mem_addr, 32'h44);
        chk("idle_mem_wdata", mem_wdata, 32'h1234);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        cyc();
        idle_inputs();

        // Both single beats; the core was served last, so DMA leads
        for (int i = 0; i < 4; i++) begin
            c_req = 1; c_addr = 32'h20; d_req = 1; d_addr = 32'h30; d_last = 1;
            #1;
            chk("alt_d_gnt", 32'(d_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_c_gnt", 32'(c_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("alt_mem_addr", mem_addr, (i % 2 == 0) ? 32'h30 : 32'h20);
            cyc();
        end
        idle_inputs();

        // 20-beat DMA burst, core idle
        for (int i = 0; i < 20; i++) begin
            d_req = 1; d_addr = 32'h100 + 32'(4 * i); d_last = (i == 19);
            #1;
            chk("b20_d_gnt", 32'(d_gnt), 32'd1);
            chk("b20_c_gnt", 32'(c_gnt), 32'd0);
            cyc();
        end
        // Back in IDLE with DMA served last: core wins the tie
        c_req = 1; d_req = 1; d_last = 1;
        #1;
        chk("b20_idle_c_gnt", 32'(c_gnt), 32'd1);
        chk("b20_idle_d_gnt", 32'(d_gnt), 32'd0);
        cyc();
        idle_inputs();

        // Long burst with core held: 8 DMA, 1 core, repeating; d_last meets handover at k=26
        for (int k = 0; k < 28; k++) begin
            d_req = 1; d_addr = 32'h200; c_req = (k >= 1); c_addr = 32'h24;
            d_last = (k >= 26);
            #1;
            chk("lb_c_gnt", 32'(c_gnt), (k % 9 == 8) ? 32'd1 : 32'd0);
            chk("lb_d_gnt", 32'(d_gnt), (k % 9 == 8) ? 32'd0 : 32'd1);
            chk("lb_excl", 32'(c_gnt & d_gnt), 32'd0);
            cyc();
        end
        idle_inputs();

        // DMA write then core read-back
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5; d_last = 1;
        #1;
        chk("wr_d_gnt", 32'(d_gnt), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        cyc();
        idle_inputs();
        c_req = 1; c_addr = 32'h40;
        #1;
        chk("wr_rb_c_gnt", 32'(c_gnt), 32'd1);
        chk("wr_rb_mem_we", 32'(mem_we), 32'd0);
        chk("wr_no_d_rvalid", 32'(d_rvalid), 32'd0);
        cyc();
        idle_inputs();
        #1;
        chk("wr_rb_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("wr_rb_c_rdata", c_rdata, 32'hA5A5A5A5);

        // Reset during beat 3 of a DMA read burst
        for (int i = 0; i < 3; i++) begin
            d_req = 1; d_addr = 32'h300 + 32'(4 * i); d_last = 0;
            reset = (i == 2);
            #1;
            chk("mr_d_gnt", 32'(d_gnt), 32'd1);
            cyc();
        end
        reset = 0;
        idle_inputs();
        #1;
        chk("mr_after_d_gnt", 32'(d_gnt), 32'd0);
        chk("mr_after_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("mr_after_d_rdata", d_rdata, 32'd0);
        c_req = 1; d_req = 1; d_last = 1;
        #1;
        chk("mr_idle_c_gnt", 32'(c_gnt), 32'd1);
        chk("mr_idle_d_gnt", 32'(d_gnt), 32'd0);
        cyc();
        idle_inputs();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
